// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM request arbiter.
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } arb_state_t;

   localparam int DEF_AW      = 22;
   localparam int DEF_DW      = 16;
   localparam int DEF_TIMEOUT = 1023;

   // Width of a counter that must be able to hold the value 'timeout'.
   function automatic int wd_bits(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/sdram_arbiter_rr_arb2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the
// port that was not served last.
module rr_arb2
   import sdram_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant,
   output logic valid
);

   // Combinational winner selection.
   always_comb begin
      grant = 1'b0;
      valid = req0 | req1;
      if (req0 && req1) begin
         grant = ~last;
      end else if (req1) begin
         grant = 1'b1;
      end else begin
         grant = 1'b0;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller request interface between two masters.
// A granted command is latched and held on the controller until ctl_done;
// a watchdog aborts commands that the controller never completes.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int TIMEOUT = DEF_TIMEOUT
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_ack,
   output logic          m0_err,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_ack,
   output logic          m1_err,
   output logic [DW-1:0] m1_rdata,
   output logic          ctl_wr_req,
   output logic          ctl_rd_req,
   output logic [AW-1:0] ctl_addr,
   output logic [DW-1:0] ctl_wdata,
   input  logic [DW-1:0] ctl_rdata,
   input  logic          ctl_done,
   output logic          timeout_flag
);

   localparam int             WDW      = wd_bits(TIMEOUT);
   localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
   localparam logic [WDW-1:0] WD_ONE   = WDW'(1);

   arb_state_t    state_r;
   logic          last_r;
   logic          port_r;
   logic          we_r;
   logic [AW-1:0] addr_r;
   logic [DW-1:0] wdata_r;
   logic [WDW-1:0] wd_r;

   logic          grant_s;
   logic          valid_s;
   logic          sel_we_s;
   logic [AW-1:0] sel_addr_s;
   logic [DW-1:0] sel_wdata_s;

   rr_arb2 u_rr_arb2 (
      .req0  (m0_req),
      .req1  (m1_req),
      .last  (last_r),
      .grant (grant_s),
      .valid (valid_s)
   );

   // Route the winning master's command fields to the latch inputs.
   always_comb begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      if (grant_s) begin
         sel_we_s    = m1_we;
         sel_addr_s  = m1_addr;
         sel_wdata_s = m1_wdata;
      end else begin
         sel_we_s    = m0_we;
         sel_addr_s  = m0_addr;
         sel_wdata_s = m0_wdata;
      end
   end

   // Command latches feed the controller directly so they stay stable in ISSUE.
   assign ctl_addr  = addr_r;
   assign ctl_wdata = wdata_r;

   // Arbiter FSM: grant, hold command, watchdog, and registered responses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         last_r       <= 1'b1;
         port_r       <= 1'b0;
         we_r         <= 1'b0;
         addr_r       <= '0;
         wdata_r      <= '0;
         wd_r         <= '0;
         ctl_wr_req   <= 1'b0;
         ctl_rd_req   <= 1'b0;
         m0_ack       <= 1'b0;
         m1_ack       <= 1'b0;
         m0_err       <= 1'b0;
         m1_err       <= 1'b0;
         m0_rdata     <= '0;
         m1_rdata     <= '0;
         timeout_flag <= 1'b0;
      end else begin
         // Acknowledge and error are single-cycle pulses.
         m0_ack <= 1'b0;
         m1_ack <= 1'b0;
         m0_err <= 1'b0;
         m1_err <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (valid_s) begin
                  port_r     <= grant_s;
                  we_r       <= sel_we_s;
                  addr_r     <= sel_addr_s;
                  wdata_r    <= sel_wdata_s;
                  wd_r       <= '0;
                  ctl_wr_req <= sel_we_s;
                  ctl_rd_req <= ~sel_we_s;
                  state_r    <= ST_ISSUE;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_ISSUE: begin
               if (ctl_done) begin
                  // Completion beats a coincident watchdog expiry.
                  ctl_wr_req <= 1'b0;
                  ctl_rd_req <= 1'b0;
                  if (port_r) begin
                     m1_ack <= 1'b1;
                     if (!we_r) begin
                        m1_rdata <= ctl_rdata;
                     end else begin
                        m1_rdata <= m1_rdata;
                     end
                  end else begin
                     m0_ack <= 1'b1;
                     if (!we_r) begin
                        m0_rdata <= ctl_rdata;
                     end else begin
                        m0_rdata <= m0_rdata;
                     end
                  end
                  state_r <= ST_RESP;
               end else if (wd_r == WD_LIMIT) begin
                  ctl_wr_req   <= 1'b0;
                  ctl_rd_req   <= 1'b0;
                  timeout_flag <= 1'b1;
                  if (port_r) begin
                     m1_ack <= 1'b1;
                     m1_err <= 1'b1;
                     if (!we_r) begin
                        m1_rdata <= '0;
                     end else begin
                        m1_rdata <= m1_rdata;
                     end
                  end else begin
                     m0_ack <= 1'b1;
                     m0_err <= 1'b1;
                     if (!we_r) begin
                        m0_rdata <= '0;
                     end else begin
                        m0_rdata <= m0_rdata;
                     end
                  end
                  state_r <= ST_RESP;
               end else begin
                  wd_r    <= wd_r + WD_ONE;
                  state_r <= ST_ISSUE;
               end
            end
            ST_RESP: begin
               last_r  <= port_r;
               state_r <= ST_IDLE;
            end
            default: begin
               ctl_wr_req <= 1'b0;
               ctl_rd_req <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level reference model.
module tb_sdram_arbiter;

   localparam int AW = 22;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_ack, m0_err, m1_ack, m1_err;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          ctl_wr_req, ctl_rd_req, ctl_done = 1'b0, timeout_flag;
   logic [AW-1:0] ctl_addr;
   logic [DW-1:0] ctl_wdata, ctl_rdata = '0;

   int checks = 0;
   int errors = 0;

   sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .ctl_wr_req(ctl_wr_req), .ctl_rd_req(ctl_rd_req), .ctl_addr(ctl_addr),
      .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata), .ctl_done(ctl_done),
      .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // A command is granted on an edge in which nothing is in flight; the k-th
   // edge after the grant completes it if ctl_done is seen, or aborts it when
   // k reaches TIMEOUT+1. The following cycle is the ack cycle, then one idle.
   logic          e_wr = 1'b0, e_rd = 1'b0, e_flag = 1'b0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0;
   logic          e_ack[2] = '{1'b0, 1'b0};
   logic          e_err[2] = '{1'b0, 1'b0};
   logic [DW-1:0] e_rdata[2] = '{16'd0, 16'd0};
   bit            m_active = 1'b0, m_resp = 1'b0, m_last = 1'b1, m_port = 1'b0, m_we = 1'b0;
   int            m_age = 0;

   task automatic model_finish(input bit err);
      m_active = 1'b0;
      m_resp   = 1'b1;
      e_wr     = 1'b0;
      e_rd     = 1'b0;
      e_ack[m_port] = 1'b1;
      e_err[m_port] = err;
      if (!m_we) e_rdata[m_port] = err ? 16'd0 : ctl_rdata;
      if (err) e_flag = 1'b1;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_wr = 1'b0; e_rd = 1'b0; e_flag = 1'b0; e_addr = '0; e_wdata = '0;
         e_ack = '{1'b0, 1'b0}; e_err = '{1'b0, 1'b0}; e_rdata = '{16'd0, 16'd0};
         m_active = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0; m_age = 0;
      end else if (m_resp) begin
         e_ack  = '{1'b0, 1'b0};
         e_err  = '{1'b0, 1'b0};
         m_last = m_port;
         m_resp = 1'b0;
      end else if (m_active) begin
         m_age++;
         if (ctl_done) model_finish(1'b0);
         else if (m_age == TO + 1) model_finish(1'b1);
      end else if (m0_req || m1_req) begin
         m_port   = (m0_req && m1_req) ? !m_last : m1_req;
         m_we     = m_port ? m1_we : m0_we;
         e_addr   = m_port ? m1_addr : m0_addr;
         e_wdata  = m_port ? m1_wdata : m0_wdata;
         e_wr     = m_we;
         e_rd     = !m_we;
         m_active = 1'b1;
         m_age    = 0;
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge clk) begin
      chk("ctl_wr_req", 32'(ctl_wr_req), 32'(e_wr));
      chk("ctl_rd_req", 32'(ctl_rd_req), 32'(e_rd));
      chk("ctl_excl", 32'(ctl_wr_req & ctl_rd_req), 32'd0);
      chk("ctl_addr", 32'(ctl_addr), 32'(e_addr));
      chk("ctl_wdata", 32'(ctl_wdata), 32'(e_wdata));
      chk("m0_ack", 32'(m0_ack), 32'(e_ack[0]));
      chk("m1_ack", 32'(m1_ack), 32'(e_ack[1]));
      chk("m0_err", 32'(m0_err), 32'(e_err[0]));
      chk("m1_err", 32'(m1_err), 32'(e_err[1]));
      chk("m0_rdata", 32'(m0_rdata), 32'(e_rdata[0]));
      chk("m1_rdata", 32'(m1_rdata), 32'(e_rdata[1]));
      chk("timeout_flag", 32'(timeout_flag), 32'(e_flag));
   end

   // ---------------- directed helpers ----------------
   task automatic do_reset;
      m0_req = 1'b0; m1_req = 1'b0; ctl_done = 1'b0;
      @(negedge clk); #2 rst = 1'b0;
      @(negedge clk); #2 rst = 1'b1;
   endtask

   int cnt;
   int grants[4];
   int ng;
   bit seen;

   initial begin
      // Reset state.
      #2 chk("reset_wr", 32'(ctl_wr_req), 32'd0);
      chk("reset_flag", 32'(timeout_flag), 32'd0);
      do_reset();

      // m0 write addr 1 data 100; done seen on the 4th ISSUE edge.
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 22'd1; m0_wdata = 16'd100;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cnt += int'(ctl_wr_req);
         if (i == 0) begin
            chk("t1_addr", 32'(ctl_addr), 32'd1);
            chk("t1_wdata", 32'(ctl_wdata), 32'd100);
         end
      end
      ctl_done = 1'b1;
      @(negedge clk);
      ctl_done = 1'b0; m0_req = 1'b0;
      cnt += int'(ctl_wr_req);
      chk("t1_wr_cycles", 32'(cnt), 32'd4);
      chk("t1_ack", 32'(m0_ack), 32'd1);
      chk("t1_err", 32'(m0_err), 32'd0);
      @(negedge clk);
      chk("t1_ack_pulse", 32'(m0_ack), 32'd0);

      // m1 read addr 1 returns 100; m0_rdata untouched.
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 22'd1;
      @(negedge clk);
      chk("t2_rd_req", 32'(ctl_rd_req), 32'd1);
      ctl_done = 1'b1; ctl_rdata = 16'd100;
      @(negedge clk);
      ctl_done = 1'b0; m1_req = 1'b0; ctl_rdata = 16'h5a5a;
      chk("t2_ack", 32'(m1_ack), 32'd1);
      chk("t2_rdata", 32'(m1_rdata), 32'd100);
      chk("t2_m0_rdata", 32'(m0_rdata), 32'd0);
      @(negedge clk);
      chk("t2_rdata_hold", 32'(m1_rdata), 32'd100);

      // Both masters continuously requesting from reset: 0,1,0,1.
      do_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'd10;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 22'd20;
      ng = 0;
      for (int i = 0; i < 40 && ng < 4; i++) begin
         @(negedge clk);
         if (m0_ack && ng < 4) begin grants[ng] = 0; ng++; end
         if (m1_ack && ng < 4) begin grants[ng] = 1; ng++; end
         ctl_done = ctl_wr_req | ctl_rd_req;
      end
      m0_req = 1'b0; m1_req = 1'b0; ctl_done = 1'b0;
      chk("t3_grant_count", 32'(ng), 32'd4);
      chk("t3_grant0", 32'(grants[0]), 32'd0);
      chk("t3_grant1", 32'(grants[1]), 32'd1);
      chk("t3_grant2", 32'(grants[2]), 32'd0);
      chk("t3_grant3", 32'(grants[3]), 32'd1);

      // Timeout: preload m0_rdata, then a read the controller never finishes.
      do_reset();
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'd5;
      @(negedge clk);
      ctl_done = 1'b1; ctl_rdata = 16'h1234;
      @(negedge clk);
      ctl_done = 1'b0; m0_req = 1'b0;
      chk("t4_preload", 32'(m0_rdata), 32'h1234);
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 22'd6;
      cnt = 0; seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (m0_ack) seen = 1'b1;
         else cnt += int'(ctl_rd_req);
      end
      m0_req = 1'b0;
      chk("t4_ack_seen", 32'(seen), 32'd1);
      chk("t4_issue_cycles", 32'(cnt), 32'd9);
      chk("t4_err", 32'(m0_err), 32'd1);
      chk("t4_rdata", 32'(m0_rdata), 32'd0);
      chk("t4_flag", 32'(timeout_flag), 32'd1);
      repeat (3) @(negedge clk);
      chk("t4_flag_sticky", 32'(timeout_flag), 32'd1);
      do_reset();
      chk("t4_flag_cleared", 32'(timeout_flag), 32'd0);

      // ctl_done on the same edge the watchdog expires: done wins.
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 22'd7;
      cnt = 0;
      for (int i = 0; i < 30 && cnt < 9; i++) begin
         @(negedge clk);
         cnt += int'(ctl_rd_req);
      end
      ctl_done = 1'b1; ctl_rdata = 16'hbeef;
      @(negedge clk);
      ctl_done = 1'b0; m0_req = 1'b0;
      chk("t5_ack", 32'(m0_ack), 32'd1);
      chk("t5_err", 32'(m0_err), 32'd0);
      chk("t5_rdata", 32'(m0_rdata), 32'hbeef);
      chk("t5_flag", 32'(timeout_flag), 32'd0);

      // Reset in the middle of ISSUE; pending m1 request is re-served.
      do_reset();
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 22'd9;
      @(negedge clk);
      chk("t6_issue", 32'(ctl_rd_req), 32'd1);
      #2 rst = 1'b0;
      #1 chk("t6_async_rd", 32'(ctl_rd_req), 32'd0);
      chk("t6_async_addr", 32'(ctl_addr), 32'd0);
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk);
      chk("t6_reissue", 32'(ctl_rd_req), 32'd1);
      chk("t6_reissue_addr", 32'(ctl_addr), 32'd9);
      ctl_done = 1'b1; ctl_rdata = 16'h0042;
      @(negedge clk);
      ctl_done = 1'b0; m1_req = 1'b0;
      chk("t6_ack", 32'(m1_ack), 32'd1);

      // Randomized traffic; the per-cycle compare process does the checking.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (m0_ack) begin
            if ($urandom_range(1) == 0) m0_req = 1'b0;
            else begin m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = DW'($urandom); end
         end else if (!m0_req && $urandom_range(2) == 0) begin
            m0_req = 1'b1; m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = DW'($urandom);
         end
         if (m1_ack) begin
            if ($urandom_range(1) == 0) m1_req = 1'b0;
            else begin m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = DW'($urandom); end
         end else if (!m1_req && $urandom_range(2) == 0) begin
            m1_req = 1'b1; m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = DW'($urandom);
         end
         ctl_done  = ($urandom_range(3) == 0);
         ctl_rdata = DW'($urandom);
      end
      m0_req = 1'b0; m1_req = 1'b0; ctl_done = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute guard so the run can never hang.
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before limit");
      $fatal(1);
   end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port round-robin arbiter that shares the single SDRAM controller request interface (wr_req/rd_req, addr, data, readdata) between two bus masters, e.g. the pattern-test driver and a readback/display master. It latches one master's command, holds it on the controller interface until the controller signals completion, and returns read data with a one-cycle acknowledge. A watchdog aborts commands the controller never completes.

## Interface
- AW, 22, address width (SDRAM word address)
- DW, 16, data width
- TIMEOUT, 1023, max cycles in ISSUE before abort (must be ≥1)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- m0_req, m1_req  in  1  command request; held high with fields stable until ack
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  AW  word address
- m0_wdata, m1_wdata  in  DW  write data
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_err, m1_err  out  1  high with ack when the command timed out
- m0_rdata, m1_rdata  out  DW  read data, valid while ack high; held until next ack to that port
- ctl_wr_req, ctl_rd_req  out  1  level requests to SDRAM controller, never both high
- ctl_addr  out  AW  command address
- ctl_wdata  out  DW  write data
- ctl_rdata  in  DW  controller read data, valid when ctl_done high
- ctl_done  in  1  one-cycle completion from controller
- timeout_flag  out  1  sticky, set on any abort, cleared only by reset

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE: if no req, stay. Otherwise pick a winner: single requester wins; both → port ≠ last_served. Latch we/addr/wdata/port into command regs, clear watchdog, go ISSUE.
- ISSUE: ctl_wr_req = we, ctl_rd_req = !we, ctl_addr/ctl_wdata from latched regs (stable for whole state). Watchdog increments each cycle.
  - ctl_done high → capture ctl_rdata (reads only; writes leave mX_rdata unchanged), err=0, go RESP.
  - watchdog == TIMEOUT and no done → err=1, rdata for that port forced 0 if read, set timeout_flag, go RESP.
  - done and timeout in the same cycle → done wins, no error.
- RESP: ctl requests low; pulse ack (and err if set) of winning port; update last_served = winner; go IDLE.
- ctl_done in IDLE or RESP ignored.
- Requester inputs changing while not granted are don't-care; only IDLE samples them.
- A req still high in the IDLE cycle after its ack is a new command.

## Timing
- Reset: state IDLE, last_served = 1 (port 0 wins first tie), all outputs 0, timeout_flag 0, command regs 0.
- Edge E0 samples req in IDLE → ctl_*_req high from E0 to the edge after ctl_done.
- ctl_done seen at edge En → ctl_*_req low and mX_ack high for exactly the cycle after En.
- Minimum req-to-ack: 2 cycles (done in first ISSUE cycle); idle gap between back-to-back commands: 1 cycle (IDLE).
- Timeout: ack/err asserted TIMEOUT+1 cycles after entry to ISSUE.
- Requester must drop req on the edge where it samples ack high.
- Reset mid-ISSUE: ctl requests drop asynchronously; command lost, no ack.
- Both masters continuously requesting: grants alternate 0,1,0,1…

## Structure
- Package sdram_arb_pkg: state encoding (IDLE/ISSUE/RESP), default AW/DW/TIMEOUT constants.
- Sub-module rr_arb2: two-input round-robin pick (req0, req1, last → grant index); FSM, command regs and watchdog stay in top.

## Test plan
- m0 write addr 1 data 100, ctl_done 3 cycles later → ctl_wr_req high 4 cycles, ctl_addr=1, ctl_wdata=100, m0_ack 1 cycle, m0_err=0.
- m1 read addr 1, ctl_rdata=100 with ctl_done → m1_ack with m1_rdata=100; m0_rdata unchanged.
- m0 and m1 request together from reset, held across 4 commands → grant order 0,1,0,1; ctl_wr_req and ctl_rd_req never both high.
- TIMEOUT=8, m0 read, ctl_done never asserted → m0_ack and m0_err after 9 ISSUE cycles, m0_rdata=0, timeout_flag=1 until reset.
- ctl_done on the same cycle the watchdog hits TIMEOUT → normal ack, err=0, timeout_flag stays 0.
- rst low during ISSUE → all outputs 0 immediately; after release, pending m1 request served first cycle as fresh command.
